i2c_req_arbiter: RTL

//  Shares one i2c_master_top between NUM_REQ independent requesters (e.g. EEPROM test FSM, sensor poller).

---
 rtl/i2c_req_arbiter_pkg.sv | 13 +
 rtl/i2c_rr_pick.sv | 28 ++
 rtl/i2c_req_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/i2c_req_arbiter_pkg.sv
// Shared encodings for the I2C request arbiter: FSM states and the latched operation code.
package i2c_req_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } arb_state_t;

   localparam logic OP_RD = 1'b1;
   localparam logic OP_WR = 1'b0;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first pending requester at or after rr_ptr, cyclically.
module i2c_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   // rr_ptr is always < NUM_REQ, so one subtraction keeps cand in range even
   // when NUM_REQ is not a power of two.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int cand;
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!found && pending[cand]) begin
            found = 1'b1;
            idx   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_master_top between NUM_REQ requesters.
// state   | meaning
// S_IDLE  | no owner; pick next pending requester and latch its request
// S_ISSUE | master req held high with latched fields until matching ack
// S_DONE  | ack/err pulse visible; one-cycle gap so the winner can drop its request
module i2c_req_arbiter
   import i2c_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_rd,
   input  logic [NUM_REQ-1:0]    req_wr,
   input  logic [NUM_REQ-1:0]    req_addr_2byte,
   input  logic [8*NUM_REQ-1:0]  req_dev_addr,
   input  logic [16*NUM_REQ-1:0] req_reg_addr,
   input  logic [8*NUM_REQ-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]    req_ack,
   output logic [NUM_REQ-1:0]    req_err,
   output logic [7:0]            req_rdata,
   output logic [NUM_REQ-1:0]    grant,
   output logic                  i2c_read_req,
   output logic                  i2c_write_req,
   output logic                  i2c_addr_2byte,
   output logic [7:0]            i2c_slave_dev_addr,
   output logic [15:0]           i2c_slave_reg_addr,
   output logic [7:0]            i2c_write_data,
   input  logic                  i2c_read_req_ack,
   input  logic                  i2c_write_req_ack,
   input  logic [7:0]            i2c_read_data,
   input  logic                  i2c_error
);

   arb_state_t         state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   idx_q;
   logic               op_q;
   logic [NUM_REQ-1:0] pending;
   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   logic               op_ack;

   assign pending = req_rd | req_wr;
   assign op_ack  = (op_q == OP_RD) ? i2c_read_req_ack : i2c_write_req_ack;

   i2c_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .pending (pending),
      .rr_ptr  (rr_ptr),
      .found   (pick_found),
      .idx     (pick_idx)
   );

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= S_IDLE;
         rr_ptr             <= '0;
         idx_q              <= '0;
         op_q               <= OP_WR;
         grant              <= '0;
         req_ack            <= '0;
         req_err            <= '0;
         req_rdata          <= '0;
         i2c_read_req       <= 1'b0;
         i2c_write_req      <= 1'b0;
         i2c_addr_2byte     <= 1'b0;
         i2c_slave_dev_addr <= '0;
         i2c_slave_reg_addr <= '0;
         i2c_write_data     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_found) begin
                  idx_q              <= pick_idx;
                  op_q               <= req_rd[pick_idx] ? OP_RD : OP_WR;
                  i2c_read_req       <= req_rd[pick_idx];
                  i2c_write_req      <= ~req_rd[pick_idx];
                  i2c_addr_2byte     <= req_addr_2byte[pick_idx];
                  i2c_slave_dev_addr <= req_dev_addr[8*pick_idx +: 8];
                  i2c_slave_reg_addr <= req_reg_addr[16*pick_idx +: 16];
                  i2c_write_data     <= req_wdata[8*pick_idx +: 8];
                  grant              <= '0;
                  grant[pick_idx]    <= 1'b1;
                  state              <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // Acks for the other operation are ignored; only the matching one completes.
               if (op_ack) begin
                  i2c_read_req   <= 1'b0;
                  i2c_write_req  <= 1'b0;
                  req_ack[idx_q] <= 1'b1;
                  req_err[idx_q] <= i2c_error;
                  if (op_q == OP_RD) req_rdata <= i2c_read_data;
                  rr_ptr         <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                  state          <= S_DONE;
               end
            end
            S_DONE: begin
               grant   <= '0;
               req_ack <= '0;
               req_err <= '0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
